// File: rtl/risc_pkg.sv
// Shared encodings for the RiSC-16 core: opcodes, system-op codes,
// control register map, STATUS bit positions and exception causes.
package risc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_e;

    localparam logic [6:0] SYS_TRAP = 7'd1;
    localparam logic [6:0] SYS_RFE  = 7'd2;
    localparam logic [6:0] SYS_MTC  = 7'd3;
    localparam logic [6:0] SYS_MFC  = 7'd4;
    localparam logic [6:0] SYS_HALT = 7'd7;

    localparam logic [2:0] CR_EPC     = 3'd0;
    localparam logic [2:0] CR_CAUSE   = 3'd1;
    localparam logic [2:0] CR_STATUS  = 3'd2;
    localparam logic [2:0] CR_PENDING = 3'd3;
    localparam logic [2:0] CR_TPERIOD = 3'd4;
    localparam logic [2:0] CR_TCOUNT  = 3'd5;

    localparam int ST_MODE  = 0;
    localparam int ST_IE    = 1;
    localparam int ST_PMODE = 2;
    localparam int ST_PIE   = 3;

    localparam logic [15:0] CAUSE_TRAP = 16'd1;
    localparam logic [15:0] CAUSE_PRIV = 16'd2;
    localparam logic [15:0] CAUSE_PROT = 16'd3;
    localparam logic [15:0] CAUSE_ILL  = 16'd4;
    localparam logic [15:0] CAUSE_IRQ  = 16'd5;

    localparam logic [15:0] DEF_EXC_VEC   = 16'h0040;
    localparam logic [15:0] DEF_USER_BASE = 16'h0300;

    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

endpackage

// File: rtl/risc_mem.sv
// Unified word-addressed memory: combinational fetch and data reads,
// synchronous write.
module risc_mem #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] iaddr,
    output logic [15:0]   idata,
    input  logic [AW-1:0] daddr,
    output logic [15:0]   ddata,
    input  logic          we,
    input  logic [15:0]   wdata
);

    logic [15:0] m [0:2**AW-1];

    assign idata = m[iaddr];
    assign ddata = m[daddr];

    always_ff @(posedge clk) begin
        if (we) m[daddr] <= wdata;
    end

endmodule

// File: rtl/risc_regfile.sv
// General registers r0..r7 (r0 hardwired to zero) and control registers
// cr0..cr7, including the cycle timer and pending-interrupt flag.
module risc_regfile
    import risc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ra1,
    input  logic [2:0]  ra2,
    output logic [15:0] rd1,
    output logic [15:0] rd2,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd,
    input  logic [2:0]  cr_ra,
    output logic [15:0] cr_rd,
    input  logic        cr_we,
    input  logic [2:0]  cr_wa,
    input  logic [15:0] cr_wd,
    input  logic        exc_we,
    input  logic [15:0] epc_wd,
    input  logic [15:0] cause_wd,
    input  logic        status_we,
    input  logic [15:0] status_wd,
    input  logic        pend_clr,
    output logic [15:0] epc,
    output logic [15:0] status,
    output logic        pend
);

    logic [15:0] r    [0:7];
    logic [15:0] cr   [0:7];
    logic [15:0] cr_d [0:7];
    logic        tmr_hold;
    logic        tmr_exp;

    assign rd1    = r[ra1];
    assign rd2    = r[ra2];
    assign cr_rd  = cr[cr_ra];
    assign epc    = cr[CR_EPC];
    assign status = cr[CR_STATUS];
    assign pend   = cr[CR_PENDING][0];

    // A software write to the period or count register overrides this cycle's tick.
    assign tmr_hold = cr_we && (cr_wa == CR_TPERIOD || cr_wa == CR_TCOUNT);

    always_comb begin
        cr_d    = cr;
        tmr_exp = 1'b0;
        if (cr[CR_TPERIOD] != 16'd0 && !tmr_hold) begin
            if (cr[CR_TCOUNT] + 16'd1 == cr[CR_TPERIOD]) begin
                cr_d[CR_TCOUNT] = 16'd0;
                tmr_exp         = 1'b1;
            end else begin
                cr_d[CR_TCOUNT] = cr[CR_TCOUNT] + 16'd1;
            end
        end
        if (cr_we) cr_d[cr_wa] = cr_wd;
        if (status_we) cr_d[CR_STATUS] = status_wd;
        if (exc_we) begin
            cr_d[CR_EPC]   = epc_wd;
            cr_d[CR_CAUSE] = cause_wd;
        end
        // Expiry in the same cycle as interrupt entry must stay pending.
        if (pend_clr) cr_d[CR_PENDING][0] = 1'b0;
        if (tmr_exp)  cr_d[CR_PENDING][0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r[i]  <= 16'd0;
                cr[i] <= 16'd0;
            end
        end else begin
            if (we && wa != 3'd0) r[wa] <= wd;
            for (int i = 0; i < 8; i++) cr[i] <= cr_d[i];
        end
    end

endmodule

// File: rtl/risc.sv
// Single-cycle RiSC-16 core with kernel/user modes, control registers,
// timer interrupt and precise exceptions.
module risc
    import risc_pkg::*;
#(
    parameter int          AW        = 16,
    parameter logic [15:0] USER_BASE = DEF_USER_BASE,
    parameter logic [15:0] EXC_VEC   = DEF_EXC_VEC
) (
    input logic clk,
    input logic reset
);

    logic [15:0] pc_q, pc_d, pc_inc;
    logic [15:0] instr, ldata, simm, ea;
    opcode_e     op;
    logic [2:0]  fa, fb, fc, ra1;
    logic [6:0]  sys_op;
    logic        is_sys, mode, ie;
    logic [15:0] rd1, rd2, cr_rd, epc, status;
    logic        pend;
    logic        rf_we, mem_we, cr_we, status_we, exc, pend_clr;
    logic [15:0] rf_wd, status_wd, exc_cause, exc_epc;

    assign op     = opcode_e'(instr[15:13]);
    assign fa     = instr[12:10];
    assign fb     = instr[9:7];
    assign fc     = instr[2:0];
    assign sys_op = instr[6:0];
    assign simm   = sext7(instr[6:0]);
    assign is_sys = (op == OP_JALR) && (sys_op != 7'd0);
    assign ra1    = (op == OP_ADD || op == OP_NAND) ? fc : fa;
    assign pc_inc = pc_q + 16'd1;
    assign ea     = rd2 + simm;
    assign mode   = status[ST_MODE];
    assign ie     = status[ST_IE];

    risc_mem #(.AW(AW)) MEM (
        .clk   (clk),
        .iaddr (pc_q[AW-1:0]),
        .idata (instr),
        .daddr (ea[AW-1:0]),
        .ddata (ldata),
        .we    (mem_we && reset),
        .wdata (rd1)
    );

    risc_regfile RF (
        .clk       (clk),
        .reset     (reset),
        .ra1       (ra1),
        .ra2       (fb),
        .rd1       (rd1),
        .rd2       (rd2),
        .we        (rf_we),
        .wa        (fa),
        .wd        (rf_wd),
        .cr_ra     (fb),
        .cr_rd     (cr_rd),
        .cr_we     (cr_we),
        .cr_wa     (fb),
        .cr_wd     (rd1),
        .exc_we    (exc),
        .epc_wd    (exc_epc),
        .cause_wd  (exc_cause),
        .status_we (status_we),
        .status_wd (status_wd),
        .pend_clr  (pend_clr),
        .epc       (epc),
        .status    (status),
        .pend      (pend)
    );

    always_comb begin
        pc_d      = pc_inc;
        rf_we     = 1'b0;
        rf_wd     = 16'd0;
        mem_we    = 1'b0;
        cr_we     = 1'b0;
        status_we = 1'b0;
        status_wd = status;
        exc       = 1'b0;
        exc_cause = 16'd0;
        exc_epc   = pc_q;
        pend_clr  = 1'b0;
        if (ie && pend) begin
            exc       = 1'b1;
            exc_cause = CAUSE_IRQ;
            pend_clr  = 1'b1;
            // Waking from HALT resumes after it rather than halting again.
            if (!mode && is_sys && sys_op == SYS_HALT) exc_epc = pc_inc;
        end else begin
            case (op)
                OP_ADD:  begin rf_we = 1'b1; rf_wd = rd2 + rd1;       end
                OP_ADDI: begin rf_we = 1'b1; rf_wd = rd2 + simm;      end
                OP_NAND: begin rf_we = 1'b1; rf_wd = ~(rd2 & rd1);    end
                OP_LUI:  begin rf_we = 1'b1; rf_wd = {instr[9:0], 6'b0}; end
                OP_LW:   begin rf_we = 1'b1; rf_wd = ldata;           end
                OP_SW: begin
                    if (mode && ea < USER_BASE) begin
                        exc       = 1'b1;
                        exc_cause = CAUSE_PROT;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
                OP_BEQ: if (rd1 == rd2) pc_d = pc_inc + simm;
                OP_JALR: begin
                    if (!is_sys) begin
                        rf_we = 1'b1;
                        rf_wd = pc_inc;
                        pc_d  = rd2;
                    end else if (sys_op == SYS_TRAP) begin
                        exc       = 1'b1;
                        exc_cause = CAUSE_TRAP;
                        exc_epc   = pc_inc;
                    end else if (sys_op == SYS_RFE || sys_op == SYS_MTC ||
                                 sys_op == SYS_MFC || sys_op == SYS_HALT) begin
                        if (mode) begin
                            exc       = 1'b1;
                            exc_cause = CAUSE_PRIV;
                        end else if (sys_op == SYS_RFE) begin
                            pc_d               = epc;
                            status_we          = 1'b1;
                            status_wd[ST_MODE] = status[ST_PMODE];
                            status_wd[ST_IE]   = status[ST_PIE];
                        end else if (sys_op == SYS_MTC) begin
                            cr_we = 1'b1;
                        end else if (sys_op == SYS_MFC) begin
                            rf_we = 1'b1;
                            rf_wd = cr_rd;
                        end else begin
                            pc_d = pc_q;
                        end
                    end else begin
                        exc       = 1'b1;
                        exc_cause = CAUSE_ILL;
                    end
                end
                default: ;
            endcase
        end
        if (exc) begin
            pc_d                = EXC_VEC;
            status_we           = 1'b1;
            status_wd[ST_MODE]  = 1'b0;
            status_wd[ST_IE]    = 1'b0;
            status_wd[ST_PMODE] = mode;
            status_wd[ST_PIE]   = ie;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= 16'd0;
        else        pc_q <= pc_d;
    end

endmodule

// File: tb/tb_risc.sv
// Directed-program bench for the RiSC-16 core: preloads MEM and checks
// architectural state at hand-computed cycle points.
module tb_risc;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    risc dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, 4'b0000, c};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input int imm);
        logic [31:0] t;
        t = imm;
        return {op, a, b, t[6:0]};
    endfunction

    function automatic logic [15:0] enc_lui(input logic [2:0] a, input logic [9:0] imm);
        return {3'b011, a, imm};
    endfunction

    task automatic ld(input logic [15:0] addr, input logic [15:0] data);
        dut.MEM.m[addr] = data;
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 128; i++)    dut.MEM.m[16'(i)] = 16'h0000;
        for (int i = 'h300; i < 'h310; i++) dut.MEM.m[16'(i)] = 16'h0000;
        for (int i = 'hFFF0; i < 'h10000; i++) dut.MEM.m[16'(i)] = 16'h0000;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;

        // Straight-line kernel arithmetic, store, load, then illegal system op.
        hold_reset();
        clr_mem();
        ld(16'h0000, enc_i(3'd1, 3'd1, 3'd0, 5));
        ld(16'h0001, enc_i(3'd1, 3'd2, 3'd1, -1));
        ld(16'h0002, enc_r(3'd0, 3'd3, 3'd1, 3'd2));
        ld(16'h0003, enc_i(3'd4, 3'd3, 3'd0, 16));
        ld(16'h0004, enc_i(3'd5, 3'd4, 3'd0, 16));
        ld(16'h0005, enc_i(3'd7, 3'd0, 3'd0, 5));
        ld(16'h0040, enc_i(3'd7, 3'd0, 3'd0, 7));
        chk("rst_pc", dut.pc_q, 16'h0000);
        chk("rst_r1", dut.RF.r[1], 16'h0000);
        release_reset();
        step(5);
        chk("s1_r2", dut.RF.r[2], 16'h0004);
        chk("s1_r3", dut.RF.r[3], 16'h0009);
        chk("s1_m10", dut.MEM.m[16'h0010], 16'h0009);
        chk("s1_r4", dut.RF.r[4], 16'h0009);
        chk("s1_pc", dut.pc_q, 16'h0005);
        step(1);
        chk("ill_pc", dut.pc_q, 16'h0040);
        chk("ill_cause", dut.RF.cr[1], 16'h0004);
        chk("ill_epc", dut.RF.cr[0], 16'h0005);
        step(3);
        chk("halt_pc", dut.pc_q, 16'h0040);

        // Enter user mode, TRAP, protection fault, privileged MTC.
        hold_reset();
        clr_mem();
        ld(16'h0000, enc_lui(3'd1, 10'h00C));
        ld(16'h0001, enc_i(3'd7, 3'd1, 3'd0, 3));
        ld(16'h0002, enc_lui(3'd3, 10'h004));
        ld(16'h0003, enc_i(3'd1, 3'd2, 3'd0, 12));
        ld(16'h0004, enc_i(3'd7, 3'd2, 3'd2, 3));
        ld(16'h0005, enc_i(3'd7, 3'd0, 3'd0, 2));
        ld(16'h0040, enc_i(3'd7, 3'd5, 3'd1, 4));
        ld(16'h0041, enc_i(3'd1, 3'd4, 3'd0, 1));
        ld(16'h0042, enc_i(3'd6, 3'd5, 3'd4, 3));
        ld(16'h0043, enc_i(3'd7, 3'd4, 3'd0, 4));
        ld(16'h0044, enc_i(3'd1, 3'd4, 3'd4, 1));
        ld(16'h0045, enc_i(3'd7, 3'd4, 3'd0, 3));
        ld(16'h0046, enc_i(3'd7, 3'd0, 3'd0, 2));
        ld(16'h0100, 16'hBEEF);
        ld(16'h0300, enc_lui(3'd1, 10'h3FF));
        ld(16'h0301, enc_i(3'd1, 3'd6, 3'd0, 1));
        ld(16'h0302, enc_i(3'd7, 3'd0, 3'd0, 1));
        ld(16'h0303, enc_i(3'd4, 3'd6, 3'd3, 0));
        ld(16'h0304, enc_i(3'd7, 3'd6, 3'd6, 3));
        ld(16'h0305, enc_i(3'd1, 3'd7, 3'd0, 7));
        ld(16'h0306, enc_i(3'd6, 3'd0, 3'd0, -1));
        release_reset();
        step(6);
        chk("rfe_pc", dut.pc_q, 16'h0300);
        chk("rfe_status", dut.RF.cr[2], 16'h000F);
        step(1);
        chk("user_lui", dut.RF.r[1], 16'hFFC0);
        step(2);
        chk("trap_pc", dut.pc_q, 16'h0040);
        chk("trap_epc", dut.RF.cr[0], 16'h0303);
        chk("trap_cause", dut.RF.cr[1], 16'h0001);
        chk("trap_status", dut.RF.cr[2], 16'h000C);
        step(4);
        chk("trap_ret_pc", dut.pc_q, 16'h0303);
        chk("trap_mfc", dut.RF.r[5], 16'h0001);
        step(1);
        chk("prot_pc", dut.pc_q, 16'h0040);
        chk("prot_cause", dut.RF.cr[1], 16'h0003);
        chk("prot_epc", dut.RF.cr[0], 16'h0303);
        chk("prot_mem", dut.MEM.m[16'h0100], 16'hBEEF);
        step(7);
        chk("prot_ret_pc", dut.pc_q, 16'h0304);
        step(1);
        chk("priv_cause", dut.RF.cr[1], 16'h0002);
        chk("priv_epc", dut.RF.cr[0], 16'h0304);
        chk("priv_cr6", dut.RF.cr[6], 16'h0000);
        step(8);
        chk("priv_resume", dut.RF.r[7], 16'h0007);

        // Periodic timer interrupt while user code spins.
        hold_reset();
        clr_mem();
        ld(16'h0000, enc_lui(3'd1, 10'h00C));
        ld(16'h0001, enc_i(3'd7, 3'd1, 3'd0, 3));
        ld(16'h0002, enc_i(3'd1, 3'd2, 3'd0, 12));
        ld(16'h0003, enc_i(3'd7, 3'd2, 3'd2, 3));
        ld(16'h0004, enc_i(3'd1, 3'd3, 3'd0, 9));
        ld(16'h0005, enc_i(3'd7, 3'd3, 3'd4, 3));
        ld(16'h0006, enc_i(3'd7, 3'd0, 3'd0, 2));
        ld(16'h0040, enc_i(3'd7, 3'd0, 3'd0, 2));
        ld(16'h0300, enc_i(3'd1, 3'd6, 3'd6, 1));
        ld(16'h0301, enc_i(3'd6, 3'd0, 3'd0, -2));
        release_reset();
        step(14);
        chk("tmr_early", dut.RF.cr[3], 16'h0000);
        step(1);
        chk("tmr_pend", dut.RF.cr[3], 16'h0001);
        chk("tmr_wrap", dut.RF.cr[5], 16'h0000);
        step(1);
        chk("irq_pc", dut.pc_q, 16'h0040);
        chk("irq_cause", dut.RF.cr[1], 16'h0005);
        chk("irq_epc", dut.RF.cr[0], 16'h0300);
        chk("irq_pclr", dut.RF.cr[3], 16'h0000);
        chk("irq_status", dut.RF.cr[2], 16'h000C);
        step(8);
        chk("tmr_pend2", dut.RF.cr[3], 16'h0001);
        step(1);
        chk("irq2_pc", dut.pc_q, 16'h0040);
        chk("irq2_epc", dut.RF.cr[0], 16'h0301);
        chk("irq2_r6", dut.RF.r[6], 16'h0008);

        // Kernel HALT woken by a timer interrupt.
        hold_reset();
        clr_mem();
        ld(16'h0000, enc_i(3'd1, 3'd3, 3'd0, 4));
        ld(16'h0001, enc_i(3'd7, 3'd3, 3'd4, 3));
        ld(16'h0002, enc_i(3'd1, 3'd2, 3'd0, 2));
        ld(16'h0003, enc_i(3'd7, 3'd2, 3'd2, 3));
        ld(16'h0004, enc_i(3'd7, 3'd0, 3'd0, 7));
        ld(16'h0005, enc_i(3'd1, 3'd5, 3'd0, 5));
        ld(16'h0006, enc_i(3'd6, 3'd0, 3'd0, -1));
        ld(16'h0040, enc_i(3'd7, 3'd0, 3'd0, 2));
        release_reset();
        step(6);
        chk("halt_hold", dut.pc_q, 16'h0004);
        chk("halt_pend", dut.RF.cr[3], 16'h0001);
        step(1);
        chk("wake_pc", dut.pc_q, 16'h0040);
        chk("wake_epc", dut.RF.cr[0], 16'h0005);
        chk("wake_status", dut.RF.cr[2], 16'h0008);
        step(1);
        chk("wake_ret", dut.pc_q, 16'h0005);
        chk("wake_ie", dut.RF.cr[2], 16'h000A);
        step(1);
        chk("wake_r5", dut.RF.r[5], 16'h0005);

        // jalr with A==B, pc wrap, then reset in the middle of a store.
        hold_reset();
        clr_mem();
        ld(16'h0000, enc_i(3'd1, 3'd1, 3'd0, -1));
        ld(16'h0001, enc_i(3'd7, 3'd1, 3'd1, 0));
        ld(16'hFFFF, enc_i(3'd6, 3'd1, 3'd1, 2));
        ld(16'h0002, enc_i(3'd7, 3'd1, 3'd7, 3));
        ld(16'h0003, enc_i(3'd4, 3'd1, 3'd0, 32));
        ld(16'h0020, 16'h1234);
        release_reset();
        step(2);
        chk("jalr_link", dut.RF.r[1], 16'h0002);
        chk("jalr_pc", dut.pc_q, 16'hFFFF);
        step(1);
        chk("beq_wrap", dut.pc_q, 16'h0002);
        step(1);
        chk("mtc_cr7", dut.RF.cr[7], 16'h0002);
        chk("at_sw", dut.pc_q, 16'h0003);
        hold_reset();
        chk("mid_rst_pc", dut.pc_q, 16'h0000);
        chk("mid_rst_r1", dut.RF.r[1], 16'h0000);
        chk("mid_rst_cr7", dut.RF.cr[7], 16'h0000);
        step(2);
        chk("mid_rst_mem", dut.MEM.m[16'h0020], 16'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
